// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: configuration sequencer in front of the pwm generator.
// Accepts settings over a valid/ready command port and applies them only on
// a PWM period boundary, so no output period is ever truncated.
// Build option: define PWM_RAMP_CTRL_SOFTSTART_EN to slew DutyCycle toward the
// target in RAMP_STEP increments every RAMP_DIV boundaries; without it the
// target duty is loaded in a single step at the first boundary.
module pwm_ramp_ctrl #(
    parameter logic [15:0] RESET_PERIOD = 16'd1000,
    parameter int unsigned RAMP_STEP    = 1,
    parameter int unsigned RAMP_DIV     = 1
) (
    input  logic        SysClk,
    input  logic        Reset,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [15:0] CmdPeriod,
    input  logic [7:0]  CmdDuty,
    input  logic        CmdBurst,
    input  logic        CmdBurstType,
    input  logic        Abort,
    output logic [15:0] Period,
    output logic [7:0]  DutyCycle,
    output logic        Burst,
    output logic        BurstType,
    output logic        Busy,
    output logic        Done
);

    if (RAMP_STEP < 1 || RAMP_STEP > 100 || RAMP_DIV < 1 || RAMP_DIV > 255) begin : g_bad_cfg
        $error("pwm_ramp_ctrl: RAMP_STEP must be 1..100 and RAMP_DIV 1..255");
    end

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
    localparam logic [1:0] ST_RAMP  = 2'd2;
    localparam logic [7:0] STEP     = 8'(RAMP_STEP);
    localparam logic [7:0] DIV_LAST = 8'(RAMP_DIV - 1);
`endif
    localparam logic [7:0] DUTY_MAX = 8'd100;

    logic [1:0]  state;
    logic [1:0]  state_nx;

    // period boundary counter
    logic [15:0] bnd_cnt;
    logic [15:0] bnd_last;
    logic        tick;

    // latched command
    logic [15:0] tgt_period;
    logic [7:0]  tgt_duty;
    logic        tgt_burst;
    logic        tgt_btype;
    logic        latch;

    // next values of the registered outputs
    logic [15:0] period_nx;
    logic [7:0]  duty_nx;
    logic        burst_nx;
    logic        btype_nx;
    logic        done_nx;

`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
    logic [7:0]  div_cnt;
    logic [7:0]  div_nx;
    logic        ramp_up;
    logic [7:0]  ramp_dist;
`endif

    // A zero period behaves as a period of one, so Tick fires every cycle.
    assign bnd_last = (Period == '0) ? '0 : Period - 16'd1;
    assign tick     = (bnd_cnt == bnd_last);

    // Boundary counter: wraps at Period-1 and restarts whenever Period changes.
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            bnd_cnt <= '0;
        end else if (tick || (period_nx != Period)) begin
            bnd_cnt <= '0;
        end else begin
            bnd_cnt <= bnd_cnt + 16'd1;
        end
    end

    // Capture the command on accept; duty requests above 100 % are clamped.
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            tgt_period <= '0;
            tgt_duty   <= '0;
            tgt_burst  <= 1'b0;
            tgt_btype  <= 1'b0;
        end else if (latch) begin
            tgt_period <= CmdPeriod;
            tgt_duty   <= (CmdDuty > DUTY_MAX) ? DUTY_MAX : CmdDuty;
            tgt_burst  <= CmdBurst;
            tgt_btype  <= CmdBurstType;
        end
    end

`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
    // Direction and remaining distance from the current duty to the target.
    always_comb begin
        ramp_up   = (tgt_duty > DutyCycle);
        ramp_dist = ramp_up ? (tgt_duty - DutyCycle) : (DutyCycle - tgt_duty);
    end
`endif

    // Sequencer: Abort overrides everything, loads happen only on a Tick.
    always_comb begin
        state_nx  = state;
        period_nx = Period;
        duty_nx   = DutyCycle;
        burst_nx  = Burst;
        btype_nx  = BurstType;
        done_nx   = 1'b0;
        latch     = 1'b0;
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
        div_nx    = div_cnt;
`endif
        if (Abort) begin
            state_nx = ST_IDLE;
            duty_nx  = '0;
            burst_nx = 1'b0;
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
            div_nx   = '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CmdValid) begin
                        latch    = 1'b1;
                        state_nx = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (tick) begin
                        period_nx = tgt_period;
                        burst_nx  = tgt_burst;
                        btype_nx  = tgt_btype;
                        if (DutyCycle == tgt_duty) begin
                            done_nx  = 1'b1;
                            state_nx = ST_IDLE;
                        end else begin
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
                            div_nx   = '0;
                            state_nx = ST_RAMP;
`else
                            duty_nx  = tgt_duty;
                            done_nx  = 1'b1;
                            state_nx = ST_IDLE;
`endif
                        end
                    end
                end
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
                ST_RAMP: begin
                    if (tick) begin
                        if (div_cnt == DIV_LAST) begin
                            div_nx = '0;
                            if (ramp_dist <= STEP) begin
                                duty_nx  = tgt_duty;
                                done_nx  = 1'b1;
                                state_nx = ST_IDLE;
                            end else if (ramp_up) begin
                                duty_nx = DutyCycle + STEP;
                            end else begin
                                duty_nx = DutyCycle - STEP;
                            end
                        end else begin
                            div_nx = div_cnt + 8'd1;
                        end
                    end
                end
`endif
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Registered outputs; CmdReady/Busy follow the next state so they move
    // on the same edge as the transition.
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            Period    <= RESET_PERIOD;
            DutyCycle <= '0;
            Burst     <= 1'b0;
            BurstType <= 1'b0;
            Done      <= 1'b0;
            CmdReady  <= 1'b1;
            Busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            Period    <= period_nx;
            DutyCycle <= duty_nx;
            Burst     <= burst_nx;
            BurstType <= btype_nx;
            Done      <= done_nx;
            CmdReady  <= (state_nx == ST_IDLE);
            Busy      <= (state_nx != ST_IDLE);
        end
    end

`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
    // Ramp divider: counts boundaries between duty steps.
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_nx;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: two instances (step 10/div 1 and step 25/div 2).
// Stimulus pushes expected output events into per-instance queues; a monitor
// pops one entry whenever Period/DutyCycle/Burst/BurstType changes or Done is
// high, including the cycle gap since the previous output event.
module tb_pwm_ramp_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid  [2];
    logic [15:0] cmd_period [2];
    logic [7:0]  cmd_duty   [2];
    logic        cmd_burst  [2];
    logic        cmd_btype  [2];
    logic        abort      [2];
    logic        ready      [2];
    logic [15:0] period     [2];
    logic [7:0]  duty       [2];
    logic        burst      [2];
    logic        btype      [2];
    logic        busy       [2];
    logic        done       [2];

    pwm_ramp_ctrl #(.RESET_PERIOD(16'd1000), .RAMP_STEP(10), .RAMP_DIV(1)) u_dut_a (
        .SysClk(clk), .Reset(rst), .CmdValid(cmd_valid[0]), .CmdReady(ready[0]),
        .CmdPeriod(cmd_period[0]), .CmdDuty(cmd_duty[0]), .CmdBurst(cmd_burst[0]),
        .CmdBurstType(cmd_btype[0]), .Abort(abort[0]), .Period(period[0]),
        .DutyCycle(duty[0]), .Burst(burst[0]), .BurstType(btype[0]),
        .Busy(busy[0]), .Done(done[0])
    );

    pwm_ramp_ctrl #(.RESET_PERIOD(16'd20), .RAMP_STEP(25), .RAMP_DIV(2)) u_dut_b (
        .SysClk(clk), .Reset(rst), .CmdValid(cmd_valid[1]), .CmdReady(ready[1]),
        .CmdPeriod(cmd_period[1]), .CmdDuty(cmd_duty[1]), .CmdBurst(cmd_burst[1]),
        .CmdBurstType(cmd_btype[1]), .Abort(abort[1]), .Period(period[1]),
        .DutyCycle(duty[1]), .Burst(burst[1]), .BurstType(btype[1]),
        .Busy(busy[1]), .Done(done[1])
    );

    typedef struct packed {
        logic [15:0] period;
        logic [7:0]  duty;
        logic        burst;
        logic        btype;
        logic        ready;
        logic        busy;
        logic        done;
        logic [31:0] gap;
    } ev_t;

    ev_t         q_a [$];
    ev_t         q_b [$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned last_ev [2];
    logic [25:0] prev [2];

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic void push(input int k, input int p, input int d, input int b,
                                 input int bt, input int bs, input int dn, input int gap);
        ev_t e;
        e.period = 16'(p);
        e.duty   = 8'(d);
        e.burst  = (b != 0);
        e.btype  = (bt != 0);
        e.busy   = (bs != 0);
        e.ready  = (bs == 0);
        e.done   = (dn != 0);
        e.gap    = 32'(gap);
        if (k == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input int k, input logic [15:0] p);
        check($sformatf("rst_period_%0d", k), 32'(period[k]), 32'(p));
        check($sformatf("rst_duty_%0d", k),   32'(duty[k]),   32'd0);
        check($sformatf("rst_burst_%0d", k),  32'(burst[k]),  32'd0);
        check($sformatf("rst_btype_%0d", k),  32'(btype[k]),  32'd0);
        check($sformatf("rst_ready_%0d", k),  32'(ready[k]),  32'd1);
        check($sformatf("rst_busy_%0d", k),   32'(busy[k]),   32'd0);
        check($sformatf("rst_done_%0d", k),   32'(done[k]),   32'd0);
    endtask

    task automatic mon_step(input int k);
        logic [25:0] snap;
        ev_t act;
        ev_t exp_e;
        int  qsize;
        snap = {period[k], duty[k], burst[k], btype[k]};
        if (rst) begin
            prev[k]    = snap;
            last_ev[k] = 0;
        end else if (snap != prev[k] || done[k]) begin
            act.period = period[k];
            act.duty   = duty[k];
            act.burst  = burst[k];
            act.btype  = btype[k];
            act.ready  = ready[k];
            act.busy   = busy[k];
            act.done   = done[k];
            act.gap    = cyc - last_ev[k];
            qsize      = (k == 0) ? q_a.size() : q_b.size();
            checks++;
            if (qsize == 0) begin
                errors++;
                $display("FAIL event_%0d unexpected: got P=%0d D=%0d B=%0d BT=%0d DN=%0d gap=%0d expected no event",
                         k, act.period, act.duty, act.burst, act.btype, act.done, act.gap);
            end else begin
                if (k == 0) exp_e = q_a.pop_front();
                else        exp_e = q_b.pop_front();
                if (act !== exp_e) begin
                    errors++;
                    $display("FAIL event_%0d: got P=%0d D=%0d B=%0d BT=%0d R=%0d BSY=%0d DN=%0d gap=%0d expected P=%0d D=%0d B=%0d BT=%0d R=%0d BSY=%0d DN=%0d gap=%0d",
                             k, act.period, act.duty, act.burst, act.btype, act.ready, act.busy, act.done, act.gap,
                             exp_e.period, exp_e.duty, exp_e.burst, exp_e.btype, exp_e.ready, exp_e.busy, exp_e.done, exp_e.gap);
                end
            end
            prev[k]    = snap;
            last_ev[k] = cyc;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0);
        mon_step(1);
    end

    task automatic issue(input int k, input logic [15:0] p, input logic [7:0] d,
                         input logic b, input logic bt);
        cmd_period[k] = p;
        cmd_duty[k]   = d;
        cmd_burst[k]  = b;
        cmd_btype[k]  = bt;
        cmd_valid[k]  = 1'b1;
        @(negedge clk);
        cmd_valid[k]  = 1'b0;
        check($sformatf("accept_ready_%0d", k), 32'(ready[k]), 32'd0);
        check($sformatf("accept_busy_%0d", k),  32'(busy[k]),  32'd1);
    endtask

    task automatic wait_ready(input int k);
        int unsigned n;
        n = 0;
        while (!ready[k] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!ready[k]) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout_%0d: got CmdReady=0 after %0d cycles expected 1", k, n);
        end
    endtask

    task automatic run_a();
        // same duty as current output: only Period/Burst/BurstType move
        push(0, 100, 0, 1, 1, 0, 1, 1000);
        issue(0, 16'd100, 8'd0, 1'b1, 1'b1);
        wait_ready(0);
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
        push(0, 50, 0, 0, 1, 1, 0, 100);
        push(0, 50, 10, 0, 1, 1, 0, 50);
        push(0, 50, 20, 0, 1, 1, 0, 50);
        push(0, 50, 30, 0, 1, 1, 0, 50);
        push(0, 50, 35, 0, 1, 0, 1, 50);
`else
        push(0, 50, 35, 0, 1, 0, 1, 100);
`endif
        issue(0, 16'd50, 8'd35, 1'b0, 1'b1);
        wait_ready(0);
        // abort one cycle after the first step (soft) / after landing (direct)
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
        push(0, 50, 35, 1, 0, 1, 0, 50);
        push(0, 50, 45, 1, 0, 1, 0, 50);
        push(0, 50, 0, 0, 0, 0, 0, 1);
`else
        push(0, 50, 80, 1, 0, 0, 1, 50);
        push(0, 50, 0, 0, 0, 0, 0, 51);
`endif
        issue(0, 16'd50, 8'd80, 1'b1, 1'b0);
        repeat (99) @(negedge clk);
        abort[0]      = 1'b1;
        cmd_valid[0]  = 1'b1;
        cmd_period[0] = 16'd200;
        cmd_duty[0]   = 8'd90;
        cmd_burst[0]  = 1'b1;
        cmd_btype[0]  = 1'b1;
        @(negedge clk);
        abort[0]     = 1'b0;
        cmd_valid[0] = 1'b0;
        check("abort_ready", 32'(ready[0]), 32'd1);
        check("abort_busy",  32'(busy[0]),  32'd0);
        repeat (120) @(negedge clk);
        // Period=0: boundary every cycle
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
        push(0, 0, 0, 1, 1, 1, 0, 149);
        push(0, 0, 10, 1, 1, 1, 0, 1);
        push(0, 0, 20, 1, 1, 0, 1, 1);
`else
        push(0, 0, 20, 1, 1, 0, 1, 149);
`endif
        issue(0, 16'd0, 8'd20, 1'b1, 1'b1);
        wait_ready(0);
    endtask

    task automatic run_b();
        // duty 150 clamps to 100
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
        push(1, 10, 0, 0, 0, 1, 0, 20);
        push(1, 10, 25, 0, 0, 1, 0, 20);
        push(1, 10, 50, 0, 0, 1, 0, 20);
        push(1, 10, 75, 0, 0, 1, 0, 20);
        push(1, 10, 100, 0, 0, 0, 1, 20);
`else
        push(1, 10, 100, 0, 0, 0, 1, 20);
`endif
        issue(1, 16'd10, 8'd150, 1'b0, 1'b0);
        wait_ready(1);
        // 101 clamps to the current 100: same-duty completion
        push(1, 10, 100, 1, 1, 0, 1, 10);
        issue(1, 16'd10, 8'd101, 1'b1, 1'b1);
        wait_ready(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k]  = 1'b0;
            cmd_period[k] = '0;
            cmd_duty[k]   = '0;
            cmd_burst[k]  = 1'b0;
            cmd_btype[k]  = 1'b0;
            abort[k]      = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check_reset(0, 16'd1000);
        check_reset(1, 16'd20);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        fork
            run_a();
            run_b();
        join
        // reset while a command is pending in ARM: it must be discarded
        @(negedge clk);
        issue(1, 16'd30, 8'd50, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_reset(0, 16'd1000);
        check_reset(1, 16'd20);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("queue_a_drained", 32'(q_a.size()), 32'd0);
        check("queue_b_drained", 32'(q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
